// File: rtl/io_out_uart_logger_pkg.sv
// Shared constants for the iCEBreaker io_out logging harness: board clock, UART timing, TX FSM encoding.
package io_out_uart_logger_pkg;

   localparam int BOARD_CLK_HZ = 12_000_000;
   localparam int UART_BAUD    = 115_200;

   localparam logic [1:0] TX_IDLE  = 2'd0;
   localparam logic [1:0] TX_START = 2'd1;
   localparam logic [1:0] TX_DATA  = 2'd2;
   localparam logic [1:0] TX_STOP  = 2'd3;

   function automatic int clk_per_bit(input int clk_hz, input int baud);
      return (clk_hz + baud / 2) / baud;
   endfunction

   localparam int DEF_CLK_PER_BIT = clk_per_bit(BOARD_CLK_HZ, UART_BAUD);

endpackage

// File: rtl/io_out_uart_logger_tx.sv
// 8N1 serialiser: load accepted only in IDLE, uart_tx falls one cycle after accept, frame is 10*CLK_PER_BIT cycles.
// Backpressure: load_rdy is low for the whole frame, so the producer holds its byte until the line is free.
module uart_tx_byte
   import io_out_uart_logger_pkg::*;
#(
   parameter int CLK_PER_BIT = DEF_CLK_PER_BIT
) (
   input  logic       CLK,
   input  logic       rst,
   input  logic       load_vld,
   input  logic [7:0] load_dat,
   output logic       load_rdy,
   output logic       uart_tx
);

   localparam int CW = $clog2(CLK_PER_BIT);
   localparam logic [CW-1:0] BAUD_TOP = CW'(CLK_PER_BIT - 1);

   logic [1:0]    state;
   logic [CW-1:0] baud_cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shift;
   logic          baud_done;

   assign baud_done = (baud_cnt == '0);
   assign load_rdy  = (state == TX_IDLE);

   // uart_tx follows state by one cycle, so the line level is purely registered
   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         state    <= TX_IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shift    <= '0;
         uart_tx  <= 1'b1;
      end else begin
         case (state)
            TX_IDLE: begin
               uart_tx <= 1'b1;
               if (load_vld) begin
                  shift    <= load_dat;
                  baud_cnt <= BAUD_TOP;
                  state    <= TX_START;
               end
            end
            TX_START: begin
               uart_tx <= 1'b0;
               if (baud_done) begin
                  baud_cnt <= BAUD_TOP;
                  bit_idx  <= '0;
                  state    <= TX_DATA;
               end else begin
                  baud_cnt <= baud_cnt - CW'(1);
               end
            end
            TX_DATA: begin
               uart_tx <= shift[0];
               if (baud_done) begin
                  shift    <= {1'b0, shift[7:1]};
                  baud_cnt <= BAUD_TOP;
                  bit_idx  <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) state <= TX_STOP;
               end else begin
                  baud_cnt <= baud_cnt - CW'(1);
               end
            end
            default: begin
               uart_tx <= 1'b1;
               if (baud_done) state <= TX_IDLE;
               else           baud_cnt <= baud_cnt - CW'(1);
            end
         endcase
      end
   end

endmodule

// File: rtl/io_out_uart_logger.sv
// Samples io_out on divided-clock rises, buffers in a FIFO, logs each byte as 8N1 UART; push->tx fall 2 cycles.
// No upstream backpressure: a sample meeting a full FIFO with no same-cycle pop is dropped and sets sticky overflow.
module io_out_uart_logger
   import io_out_uart_logger_pkg::*;
#(
   parameter int CLK_PER_BIT    = DEF_CLK_PER_BIT,
   parameter int FIFO_DEPTH     = 4,
   parameter bit ONLY_ON_CHANGE = 1'b1
) (
   input  logic       CLK,
   input  logic       rst,
   input  logic       dut_clk,
   input  logic [7:0] dut_out,
   output logic       uart_tx,
   output logic       busy,
   output logic       overflow
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);

   logic          dut_clk_q;
   logic          rise;
   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic [7:0]    last_pushed;
   logic          seen_first;
   logic          accept;
   logic          full;
   logic          empty;
   logic          push;
   logic          pop;
   logic          drop;
   logic          load_rdy;

   // dut_clk is generated in this clock domain, so a plain delay is enough for edge detection
   assign rise   = dut_clk & ~dut_clk_q;
   assign accept = rise & (!ONLY_ON_CHANGE || !seen_first || (dut_out != last_pushed));
   assign full   = (count == DEPTH_CNT);
   assign empty  = (count == '0);
   assign pop    = ~empty & load_rdy;
   assign push   = accept & (~full | pop);
   assign drop   = accept & full & ~pop;
   assign busy   = ~load_rdy | ~empty;

   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         dut_clk_q   <= 1'b0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         last_pushed <= '0;
         seen_first  <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         dut_clk_q <= dut_clk;
         if (push) begin
            wr_ptr      <= wr_ptr + AW'(1);
            last_pushed <= dut_out;
            seen_first  <= 1'b1;
         end
         if (pop)  rd_ptr   <= rd_ptr + AW'(1);
         if (drop) overflow <= 1'b1;
         case ({push, pop})
            2'b10:   count <= count + (AW + 1)'(1);
            2'b01:   count <= count - (AW + 1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: the pointers alone define what is valid
   always_ff @(posedge CLK) begin
      if (push) mem[wr_ptr] <= dut_out;
   end

   uart_tx_byte #(
      .CLK_PER_BIT (CLK_PER_BIT)
   ) u_tx (
      .CLK      (CLK),
      .rst      (rst),
      .load_vld (~empty),
      .load_dat (mem[rd_ptr]),
      .load_rdy (load_rdy),
      .uart_tx  (uart_tx)
   );

endmodule

// File: doc/io_out_uart_logger.md
Name: io_out_uart_logger

Overview:
Downstream consumer of the DUT's 8-bit io_out bus on the iCEBreaker test harness. Samples io_out on each rising edge of the divided DUT clock and buffers samples in a small FIFO. Serialises them as raw 8N1 UART bytes on a spare PMOD pin so a host can log DUT behaviour without a logic analyser. Runs entirely in the 12 MHz board clock domain, next to the clock divider and reset-delay logic.

Parameters:
CLK_PER_BIT, 104, board-clock cycles per UART bit (12 MHz / 115200, rounded)
FIFO_DEPTH, 4, sample FIFO entries; power of two, minimum 2
ONLY_ON_CHANGE, 1, 1 = enqueue only samples differing from the last enqueued; 0 = enqueue every sample

Ports:
CLK  input  1  board clock, 12 MHz
rst  input  1  asynchronous, active-high reset
dut_clk  input  1  divided DUT clock, generated from CLK in the CLK domain
dut_out  input  8  DUT io_out bus
uart_tx  output  1  serial output, idle high
busy  output  1  high while FSM is not IDLE or FIFO is non-empty
overflow  output  1  sticky, set when a sample is dropped because the FIFO is full

Behaviour:
- Reset is asynchronous and active-high. It forces uart_tx=1, busy=0 and overflow=0, FIFO empty, FSM IDLE, and clears the first-sample flag.
- Edge detect: dut_clk_q <= dut_clk. rise = dut_clk & ~dut_clk_q. No synchroniser, because dut_clk is CLK-domain.
- Sampling: dut_out is captured at the CLK edge where rise=1, i.e. one CLK cycle after dut_clk goes high, once DUT outputs have settled.
- Filter, when ONLY_ON_CHANGE=1: a sample is accepted if the first-sample flag is clear, or if it differs from last_pushed. On acceptance, last_pushed is updated and the flag is set. The first sample after reset is always accepted, including 0x00.
- Filter, when ONLY_ON_CHANGE=0: every sample is accepted.
- FIFO push when FIFO is not full: an accepted sample is written.
- FIFO push when FIFO is full: the write still succeeds if a pop occurs in the same cycle. Otherwise the sample is dropped and overflow is set; overflow stays set until rst.
- last_pushed is updated only on a successful write.
- FIFO pointers wrap modulo FIFO_DEPTH. The count is $clog2(FIFO_DEPTH)+1 bits.
- TX FSM state IDLE: uart_tx=1. When the FIFO is non-empty, pop into the shift register and go to START.
- TX FSM state START: uart_tx=0 for CLK_PER_BIT cycles.
- TX FSM state DATA: 8 bits, LSB first, each held CLK_PER_BIT cycles. Bit index counter is 3 bits.
- TX FSM state STOP: uart_tx=1 for CLK_PER_BIT cycles, then return to IDLE.
- Frame length is exactly 10*CLK_PER_BIT cycles. The baud counter is $clog2(CLK_PER_BIT) bits and reloads at each state/bit boundary.
- Back-to-back frames: IDLE lasts exactly one cycle between STOP and the next START.
- Latency: push at the rise-detect edge N, pop in IDLE at edge N+1, uart_tx falls at edge N+2.
- uart_tx is registered with no combinational path to any input.
- rst mid-frame: uart_tx returns high immediately (asynchronously). The partial frame is abandoned and the FIFO contents are discarded.
- dut_clk held low (for example while the harness reset is asserted): no samples are taken and the FSM drains the FIFO normally.

Decomposition:
- Shared harness package holds:
  - TX state encoding (IDLE/START/DATA/STOP, 2 bits)
  - default CLK_PER_BIT constant
  - board clock frequency constant
- One sub-module, uart_tx_byte: serialiser and baud counter with a valid/ready load interface.
- The FIFO, edge detect and change filter stay inline in io_out_uart_logger.

Test Plan:
1. Reset behaviour: hold rst=1, toggle dut_clk and dut_out -> uart_tx=1, busy=0, overflow=0 throughout. Release rst -> still idle.
2. Single frame: dut_out=0xA5, one dut_clk rise -> uart_tx falls exactly 2 CLK after the detect edge. Bits at 104-cycle spacing are 0 (start), 1,0,1,0,0,1,0,1 (data), 1 (stop). busy deasserts after 1040 cycles.
3. Change filter: dut_out held at 0x3C across 3 rises, then 0x3D on the 4th rise -> exactly two frames, 0x3C then 0x3D. Repeat with ONLY_ON_CHANGE=0 -> four frames.
4. First sample zero: after reset, dut_out=0x00 with one rise -> one frame carrying 0x00.
5. Overflow: six distinct values (0x01..0x06), with rises every 20 CLK cycles and FIFO_DEPTH=4:
   - 0x01 goes to TX and 0x02..0x05 fill the FIFO.
   - 0x06 is dropped and overflow=1.
   - Exactly five frames are sent, 0x01..0x05.
   - overflow stays 1 until rst.
6. Reset mid-frame: assert rst during data bit 3 of 0xF0 -> uart_tx=1 in the same cycle and busy=0. After release, 0x81 with one rise -> clean frame 0x81 with correct timing.
